// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb
//   Multi-port integer register file with an integrated busy-bit scoreboard.
//   ID reads operands and checks hazards via rbusy. Issue marks the destination
//   register busy. Each writeback port writes data and clears the busy bit.
//   The write-to-read bypass and the hardwired x0 are both optional.
//   Reset is synchronous and active-low. While rstn is low, every read-side
//   output is forced to zero.

module regfile_mp_sb #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      rbusy,
    input  logic [NWR-1:0]      wen,
    input  logic [NWR*AW-1:0]   waddr,
    input  logic [NWR*XLEN-1:0] wdata,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_rd,
    output logic [NREG-1:0]     busy_vec
);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;

    // Per-register view of this cycle's writebacks after port arbitration.
    logic [NREG-1:0] wr_hit;
    logic [XLEN-1:0] wr_val [NREG];
    logic [NREG-1:0] iss_hit;
    logic [NREG-1:0] busy_nxt;

    // Resolve writes per register. Ports are scanned in ascending order,
    // so the highest-indexed enabled port that targets a register wins.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            wr_hit[r] = 1'b0;
            wr_val[r] = '0;
            for (int j = 0; j < NWR; j++) begin
                if (wen[j] && (waddr[j*AW +: AW] == AW'(r))) begin
                    wr_hit[r] = 1'b1;
                    wr_val[r] = wdata[j*XLEN +: XLEN];
                end
            end
        end
    end

    // Decode the issue destination into a one-hot vector.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            iss_hit[r] = iss_valid && (iss_rd == AW'(r));
        end
    end

    // Compute the next scoreboard state. A same-cycle issue beats a
    // writeback because the newer producer owns the register.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            busy_nxt[r] = iss_hit[r] || (busy[r] && !wr_hit[r]);
        end
        if (ZERO_REG != 0) begin
            busy_nxt[0] = 1'b0;
        end
    end

    // Register storage. Reset clears every entry. When x0 is hardwired,
    // writes to it are dropped.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (wr_hit[r] && !((ZERO_REG != 0) && (r == 0))) begin
                    regs[r] <= wr_val[r];
                end
            end
        end
    end

    // Scoreboard register. Reset discards any in-flight producers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    // Combinational read ports. Evaluation order sets priority:
    // the hardwired zero beats the bypass, and the bypass beats stored data.
    always_comb begin
        rdata = '0;
        rbusy = '0;
        for (int k = 0; k < NRD; k++) begin
            logic [AW-1:0] a;
            a = raddr[k*AW +: AW];
            rdata[k*XLEN +: XLEN] = regs[a];
            rbusy[k]              = busy[a];
            if ((BYPASS != 0) && wr_hit[a]) begin
                rdata[k*XLEN +: XLEN] = wr_val[a];
                // The busy bit is released only if no newer issue re-claims it.
                if (!iss_hit[a]) begin
                    rbusy[k] = 1'b0;
                end
            end
            if ((ZERO_REG != 0) && (a == '0)) begin
                rdata[k*XLEN +: XLEN] = '0;
                rbusy[k]              = 1'b0;
            end
            if (!rstn) begin
                rdata[k*XLEN +: XLEN] = '0;
                rbusy[k]              = 1'b0;
            end
        end
    end

    // Raw scoreboard view for debug and stall logic. It reads as zero in reset.
    always_comb begin
        busy_vec = rstn ? busy : '0;
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb_regfile_mp_sb
//   Directed bench for regfile_mp_sb. It runs two instances that share every
//   input. u_dut has the bypass enabled and u_nb has it disabled. Expected
//   values are hand-computed constants.

module tb_regfile_mp_sb;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int NWR  = 2;
    localparam int AW   = 5;

    logic                clk = 1'b0;
    logic                rstn;
    logic [NRD*AW-1:0]   raddr;
    logic [NWR-1:0]      wen;
    logic [NWR*AW-1:0]   waddr;
    logic [NWR*XLEN-1:0] wdata;
    logic                iss_valid;
    logic [AW-1:0]       iss_rd;

    logic [NRD*XLEN-1:0] rdata_b, rdata_n;
    logic [NRD-1:0]      rbusy_b, rbusy_n;
    logic [NREG-1:0]     busy_vec_b, busy_vec_n;

    int n_checks = 0;
    int n_fails  = 0;

    regfile_mp_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR),
                    .BYPASS(1), .ZERO_REG(1)) u_dut (
        .clk(clk), .rstn(rstn), .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b),
        .wen(wen), .waddr(waddr), .wdata(wdata), .iss_valid(iss_valid),
        .iss_rd(iss_rd), .busy_vec(busy_vec_b)
    );

    regfile_mp_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR),
                    .BYPASS(0), .ZERO_REG(1)) u_nb (
        .clk(clk), .rstn(rstn), .raddr(raddr), .rdata(rdata_n), .rbusy(rbusy_n),
        .wen(wen), .waddr(waddr), .wdata(wdata), .iss_valid(iss_valid),
        .iss_rd(iss_rd), .busy_vec(busy_vec_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        wen       = '0;
        iss_valid = 1'b0;
    endtask

    task automatic set_rd(input int k, input logic [AW-1:0] a);
        raddr[k*AW +: AW] = a;
    endtask

    task automatic set_wr(input int j, input logic [AW-1:0] a, input logic [31:0] d);
        wen[j]                 = 1'b1;
        waddr[j*AW +: AW]      = a;
        wdata[j*XLEN +: XLEN]  = d;
    endtask

    task automatic issue(input logic [AW-1:0] r);
        iss_valid = 1'b1;
        iss_rd    = r;
    endtask

    initial begin
        rstn = 1'b0; raddr = '0; waddr = '0; wdata = '0; iss_rd = '0;
        idle();
        tick(); tick();
        rstn = 1'b1;

        // Put some state in place, then reset in the middle of it.
        set_wr(0, 5'd1, 32'h0000_0111); set_wr(1, 5'd2, 32'h0000_0222); issue(5'd3);
        tick(); idle();
        set_rd(0, 5'd1); set_rd(1, 5'd2); settle();
        chk("pre_reset_r1", rdata_b[31:0], 32'h0000_0111);
        chk("pre_reset_busy", busy_vec_b, 32'h0000_0008);
        rstn = 1'b0; settle();
        chk("rst_low_rdata0", rdata_b[31:0], 32'h0);
        chk("rst_low_rdata1", rdata_b[63:32], 32'h0);
        chk("rst_low_busy_vec", busy_vec_b, 32'h0);
        tick(); tick();
        rstn = 1'b1; settle();
        chk("post_reset_r1", rdata_b[31:0], 32'h0);
        chk("post_reset_r2", rdata_n[63:32], 32'h0);
        chk("post_reset_busy", busy_vec_b, 32'h0);

        // Basic write then read. A write to r0 is dropped.
        set_wr(0, 5'd5, 32'hDEAD_BEEF); set_rd(0, 5'd9); tick(); idle();
        set_rd(0, 5'd5); settle();
        chk("basic_rdata0", rdata_b[31:0], 32'hDEAD_BEEF);
        chk("basic_rdata0_nb", rdata_n[31:0], 32'hDEAD_BEEF);
        chk("basic_rbusy0", {31'b0, rbusy_b[0]}, 32'h0);
        set_wr(0, 5'd0, 32'h0000_1234); set_rd(0, 5'd0); settle();
        chk("r0_bypass_zero", rdata_b[31:0], 32'h0);
        tick(); idle(); settle();
        chk("r0_reads_zero", rdata_b[31:0], 32'h0);
        chk("r0_reads_zero_nb", rdata_n[31:0], 32'h0);

        // Two ports write different registers in the same cycle.
        set_wr(0, 5'd20, 32'hA0A0_0020); set_wr(1, 5'd21, 32'hB1B1_0021); tick(); idle();
        set_rd(0, 5'd20); set_rd(1, 5'd21); settle();
        chk("dual_wr_r20", rdata_b[31:0], 32'hA0A0_0020);
        chk("dual_wr_r21", rdata_n[63:32], 32'hB1B1_0021);

        // Port conflict on r7: the highest port wins. Compare bypass and no-bypass.
        set_wr(0, 5'd7, 32'h0000_0055); tick(); idle();
        set_wr(0, 5'd7, 32'h0000_0011); set_wr(1, 5'd7, 32'h0000_0022);
        set_rd(1, 5'd7); settle();
        chk("conflict_bypass_same_cycle", rdata_b[63:32], 32'h0000_0022);
        chk("conflict_nobypass_old", rdata_n[63:32], 32'h0000_0055);
        tick(); idle(); settle();
        chk("conflict_stored", rdata_b[63:32], 32'h0000_0022);
        chk("conflict_stored_nb", rdata_n[63:32], 32'h0000_0022);

        // Scoreboard: issue r9, then write it back with 0xAA.
        issue(5'd9); set_rd(0, 5'd9); settle();
        chk("issue_not_same_cycle", {31'b0, rbusy_b[0]}, 32'h0);
        tick(); idle(); settle();
        chk("busy9_set", busy_vec_b, 32'h0000_0200);
        chk("rbusy9", {31'b0, rbusy_b[0]}, 32'h1);
        chk("rbusy9_nb", {31'b0, rbusy_n[0]}, 32'h1);
        set_wr(1, 5'd9, 32'h0000_00AA); settle();
        chk("wb9_rbusy_bypass", {31'b0, rbusy_b[0]}, 32'h0);
        chk("wb9_rdata_bypass", rdata_b[31:0], 32'h0000_00AA);
        chk("wb9_rbusy_nb", {31'b0, rbusy_n[0]}, 32'h1);
        chk("wb9_rdata_nb", rdata_n[31:0], 32'h0);
        tick(); idle(); settle();
        chk("busy9_cleared", busy_vec_b, 32'h0);
        chk("r9_stored", rdata_n[31:0], 32'h0000_00AA);

        // A simultaneous issue and writeback to r12 leaves the register busy.
        issue(5'd12); set_wr(0, 5'd12, 32'h0000_0077); set_rd(0, 5'd12); tick(); idle(); settle();
        chk("iss_wb_busy12", busy_vec_b, 32'h0000_1000);
        chk("iss_wb_data12", rdata_b[31:0], 32'h0000_0077);
        chk("iss_wb_rbusy12", {31'b0, rbusy_b[0]}, 32'h1);
        issue(5'd12); set_wr(1, 5'd12, 32'h0000_0088); settle();
        chk("reissue_rbusy_held", {31'b0, rbusy_b[0]}, 32'h1);
        chk("reissue_rdata_byp", rdata_b[31:0], 32'h0000_0088);
        tick(); idle();
        set_wr(0, 5'd12, 32'h0000_0099); tick(); idle();
        issue(5'd0); tick(); idle(); settle();
        chk("issue_r0_ignored", busy_vec_b, 32'h0);
        chk("issue_r0_ignored_nb", busy_vec_n, 32'h0);

        // Reset while r3 and r4 are busy, then a late writeback to r3.
        issue(5'd3); tick(); issue(5'd4); tick(); idle(); settle();
        chk("midflight_busy", busy_vec_b, 32'h0000_0018);
        rstn = 1'b0; tick(); rstn = 1'b1; settle();
        chk("midflight_reset_busy", busy_vec_b, 32'h0);
        set_wr(0, 5'd3, 32'h0000_3333); tick(); idle();
        set_rd(0, 5'd3); settle();
        chk("late_wb_data", rdata_b[31:0], 32'h0000_3333);
        chk("late_wb_busy", busy_vec_b, 32'h0);
        chk("late_wb_rbusy", {31'b0, rbusy_b[0]}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
